imem_loader: RTL

//  Writer side of the instruction-memory interface: receives a framed byte stream, packs bytes into 32-bit

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_word_packer.sv | 51 +++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and frame constants for the instruction-memory loader
// Contents:
//   state_t       loader FSM states, IDLE..ERR
//   SYNC_BYTE     frame start marker
//   takes_bytes() 1 for the states in which a stream byte may be accepted
package imem_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic logic takes_bytes(input state_t s);
    return (s == ST_SYNC) || (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
           (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs a byte stream into 32-bit little-endian words
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   clear            restart packing at lane 0 (wins over byte_en)
//   byte_en          byte_in is consumed this cycle
//   byte_in[7:0]     incoming byte, stored into the current lane
//   word_full        1 while the byte completing a word is being consumed
//   word[31:0]       packed word, including the byte being consumed this cycle
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] lanes_q, lanes_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    if (clear) begin
      byte_idx_d = '0;
      lanes_d    = '0;
    end else if (byte_en) begin
      lanes_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  // Word is presented combinationally so the loader can register it on the
  // same edge that accepts the last byte, giving a one-cycle write latency.
  assign word_full = byte_en && !clear && (byte_idx_q == 2'd3);
  assign word      = lanes_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      lanes_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that writes InstructionMemory and holds the CPU until verified
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid/byte_data  stream byte offered by the source
//   byte_ready            byte accepted this cycle when byte_valid is also high
//   im_we/im_addr/im_wdata instruction-memory write port, byte address = word_index*4
//   cpu_hold              1 holds the CPU (pc and register file) in reset
//   done / error          image verified / length or checksum failure
//   words_loaded          words written in the current load
// Frame: A5 | LEN lo | LEN hi | 4*N data bytes, LSB first | CHK (XOR of LEN and data bytes)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned TAM   = 1023,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_loaded
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   wl_q, wl_d;
  logic [7:0]         chk_q, chk_d;
  logic [31:0]        im_addr_q, im_addr_d;
  logic [31:0]        im_wdata_q, im_wdata_d;

  logic               xfer;
  logic               pack_clear;
  logic               pack_en;
  logic               word_full;
  logic [31:0]        pack_word;

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (reset),
    .clear     (pack_clear),
    .byte_en   (pack_en),
    .byte_in   (byte_data),
    .word_full (word_full),
    .word      (pack_word)
  );

  assign byte_ready = takes_bytes(state_q);
  assign xfer       = byte_valid && byte_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wl_d       = wl_q;
    chk_d      = chk_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    pack_clear = 1'b0;
    pack_en    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_SYNC;
          len_d      = '0;
          wl_d       = '0;
          chk_d      = '0;
          pack_clear = 1'b1;
        end
      end

      ST_SYNC: begin
        if (xfer && (byte_data == SYNC_BYTE)) state_d = ST_LEN_LO;
      end

      ST_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_data;
          chk_d      = chk_q ^ byte_data;
          state_d    = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          chk_d       = chk_q ^ byte_data;
          pack_clear  = 1'b1;
          if ({{(32-LEN_W){1'b0}}, len_d} > TAM + 1) state_d = ST_ERR;
          else if (len_d == '0)                      state_d = ST_CHK;
          else                                       state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (xfer) begin
          pack_en = 1'b1;
          chk_d   = chk_q ^ byte_data;
          if (word_full) begin
            // Address and data are captured here and held until the next word.
            im_addr_d  = {{(30-LEN_W){1'b0}}, wl_q, 2'b00};
            im_wdata_d = pack_word;
            state_d    = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        wl_d    = wl_q + 1'b1;
        state_d = (wl_d == len_q) ? ST_CHK : ST_DATA;
      end

      ST_CHK: begin
        if (xfer) state_d = (byte_data == chk_q) ? ST_DONE : ST_ERR;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      wl_q       <= '0;
      chk_q      <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wl_q       <= wl_d;
      chk_q      <= chk_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  // Status outputs decode straight from the state register, so the hold
  // reasserts on the same edge that a restart leaves DONE.
  assign im_we        = (state_q == ST_WRITE);
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign cpu_hold     = (state_q != ST_DONE);
  assign words_loaded = wl_q;

endmodule
